spi_adc_responder: RTL and testbench
====================================

Name: spi_adc_responder

Overview:
- SPI responder modelling the MCP3002-class 10-bit ADC at the far end of spi2adc.
- Decodes the command frame spi2adc drives on adc_cs/adc_sck/sdata_to_adc and returns a 10-bit conversion on sdata_from_adc.
- Samples come from parallel inputs. Used in board-free simulation of the audio loop, and as an FPGA-internal loopback source in place of the physical ADC.
- All SPI pins are oversampled in the sysclk domain.

Parameters:
SYNC_STAGES, 2, synchroniser depth on cs/sck/sdi (minimum 2)
DATA_W, 10, conversion width; frame bit counts below assume 10

Ports:
sysclk  input  1  system clock (50 MHz)
rst_n  input  1  synchronous active-low reset
adc_cs  input  1  chip select from initiator, low active
adc_sck  input  1  serial clock from initiator
sdata_to_adc  input  1  command bits from initiator
sdata_from_adc  output  1  conversion bits to initiator
sdo_oe  output  1  1 while responder owns the data line (pad tristate control)
ch0_data  input  DATA_W  analogue-equivalent value for CH0
ch1_data  input  DATA_W  analogue-equivalent value for CH1
frame_done  output  1  one-sysclk pulse after D0 has been driven
last_sample  output  DATA_W  value returned in the most recent frame
last_chan  output  1  odd/sign bit of the most recent frame
abort_err  output  1  one-sysclk pulse when cs rises before D0 is driven

Behaviour:
- Reset: synchronous on rst_n=0. All outputs 0, state IDLE, counters 0, synchroniser flops loaded with idle levels (cs=1, sck=0, sdi=0). Reset mid-frame discards the frame with no abort_err.
- Input conditioning: cs, sck and sdi each pass through SYNC_STAGES flops, then one edge-detect flop.
  - Rising/falling SCK events are one-cycle strobes.
  - Pin-to-action latency is SYNC_STAGES+1 sysclk. sdata_from_adc changes 3 sysclk (default) after the pin falling edge of SCK.
  - Requires sysclk >= 8x SCK.
- States:
  - IDLE: sdo_oe=0, sdata_from_adc=0. cs falling edge -> WAIT_START.
  - WAIT_START: on each SCK rising edge, sample sdi. 1 -> CONFIG with cfg_cnt=0. 0 -> stay; leading zeros are ignored.
  - CONFIG: on rising edges cfg_cnt 0,1,2 latch sgl, odd, msbf respectively.
    - On the odd-bit edge (cfg_cnt=1), capture the sample into the hold register (sample-and-hold point).
    - On the falling edge after the msbf edge, assert sdo_oe=1, drive the null bit 0, and go to DATA with bit_idx=DATA_W-1.
  - DATA: on each subsequent falling edge drive hold[bit_idx], then decrement.
    - After D0 is driven, pulse frame_done; update last_sample and last_chan in the same cycle.
    - Then go to TRAIL.
  - TRAIL: drive 0 on further falling edges. sdo_oe stays 1 until cs rises.
- Hold value:
  - sgl=1: odd ? ch1_data : ch0_data.
  - sgl=0 (pseudo-differential): odd=0 gives ch0-ch1, odd=1 gives ch1-ch0. Compute at DATA_W+1 bits; a negative result saturates to 0.
- msbf is latched but ignored. The output is always MSB-first with zero trailer.
- cs rising in any state -> IDLE in the same cycle it is detected, with sdo_oe=0 and sdata_from_adc=0.
  - In CONFIG or DATA, or after the null bit, also pulse abort_err.
  - In WAIT_START or TRAIL, no error.
- A cs falling edge detected in the same cycle as an SCK edge: the cs event wins and that SCK edge is ignored.
- SCK edges while cs is high are ignored.
- ch0_data/ch1_data changes after the hold point do not affect the frame in progress.
- Back-to-back frames: cs high for at least SYNC_STAGES+2 sysclk is guaranteed by the initiator. Each frame captures a fresh sample.

Decomposition:
- Shared package: state encoding (IDLE, WAIT_START, CONFIG, DATA, TRAIL), CFG_BITS=3, default DATA_W.
- One natural sub-module: sync_edge_det, a SYNC_STAGES synchroniser plus rise/fall strobes. Instantiate it three times (cs, sck, sdi); only the sck instance uses both strobes.

Test Plan:
- Single-ended CH1: ch1_data=10'h2A5, command 1,1,1,1 -> null 0, then bits 1010100101 MSB-first on successive falling edges. frame_done once; last_sample=10'h2A5, last_chan=1.
- Leading zeros: three 0 bits then command 1,1,0,1 with ch0_data=10'h3FF -> response aligned after the real start bit, all ten 1s.
- Differential: ch0=10'd100, ch1=10'd300. Cmd sgl=0, odd=1 returns 200. Cmd sgl=0, odd=0 returns 0 (saturated).
- Hold point: ch0_data changes from 10'h155 to 10'h0AA after the odd-bit edge -> frame returns 10'h155. The next frame returns 10'h0AA.
- Abort: cs rises after D5 is driven -> abort_err single pulse, sdo_oe=0 within SYNC_STAGES+1 cycles, no frame_done, last_sample unchanged.
- Reset mid-DATA: rst_n low for 1 cycle -> all outputs 0 next cycle, no abort_err. The following full frame completes correctly.

Source files
------------

// File: rtl/spi_adc_responder_pkg.sv
// Shared types and constants for the MCP3002-class SPI ADC responder.
package spi_adc_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_CONFIG,
    ST_DATA,
    ST_TRAIL
  } state_t;

  // Configuration bits following the start bit: sgl, odd, msbf.
  localparam int unsigned CFG_BITS   = 3;
  localparam int unsigned CFG_CNT_W  = $clog2(CFG_BITS + 1);
  localparam int unsigned DATA_W_DEF = 10;

endpackage

// File: rtl/spi_adc_responder_sync_edge_det.sv
// Multi-stage synchroniser for one asynchronous pin, followed by a single
// edge-detect flop producing one-cycle rise/fall strobes.
module spi_adc_responder_sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_VAL    = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the pin through the synchroniser and remember the previous level.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{IDLE_VAL}};
      r_prev <= IDLE_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI responder emulating an MCP3002-class 10-bit ADC: decodes the
// start/sgl/odd/msbf command and returns a held conversion MSB-first.
module spi_adc_responder
  import spi_adc_responder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = DATA_W_DEF
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              adc_cs,
  input  logic              adc_sck,
  input  logic              sdata_to_adc,
  output logic              sdata_from_adc,
  output logic              sdo_oe,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic [DATA_W-1:0] ch1_data,
  output logic              frame_done,
  output logic [DATA_W-1:0] last_sample,
  output logic              last_chan,
  output logic              abort_err
);

  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0]     IDX_MSB  = IDX_W'(DATA_W - 1);
  localparam logic [CFG_CNT_W-1:0] CNT_SGL  = CFG_CNT_W'(0);
  localparam logic [CFG_CNT_W-1:0] CNT_ODD  = CFG_CNT_W'(1);
  localparam logic [CFG_CNT_W-1:0] CNT_DONE = CFG_CNT_W'(CFG_BITS);

  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_sck_rise, w_sck_fall, w_unused_sck_lvl;
  logic w_sdi_lvl, w_unused_sdi_rise, w_unused_sdi_fall;

  spi_adc_responder_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
    .i_clk(sysclk), .i_rst_n(rst_n), .i_d(adc_cs),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_adc_responder_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sck (
    .i_clk(sysclk), .i_rst_n(rst_n), .i_d(adc_sck),
    .o_level(w_unused_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_adc_responder_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sdi (
    .i_clk(sysclk), .i_rst_n(rst_n), .i_d(sdata_to_adc),
    .o_level(w_sdi_lvl), .o_rise(w_unused_sdi_rise), .o_fall(w_unused_sdi_fall)
  );

  state_t                r_state, w_nxt_state;
  logic [CFG_CNT_W-1:0]  r_cfg_cnt, w_nxt_cfg_cnt;
  logic                  r_sgl, w_nxt_sgl;
  logic                  r_odd, w_nxt_odd;
  logic                  r_msbf_unused, w_nxt_msbf;
  logic [DATA_W-1:0]     r_hold, w_nxt_hold;
  logic [IDX_W-1:0]      r_bit_idx, w_nxt_bit_idx;
  logic                  r_sdo, w_nxt_sdo;
  logic                  r_sdo_oe, w_nxt_sdo_oe;
  logic                  r_frame_done, w_nxt_frame_done;
  logic                  r_abort, w_nxt_abort;
  logic [DATA_W-1:0]     r_last_sample, w_nxt_last_sample;
  logic                  r_last_chan, w_nxt_last_chan;

  logic [DATA_W-1:0]     w_hold_val;
  logic [DATA_W:0]       w_diff;

  // Sample to hold, with the odd bit taken live from the current sdi level;
  // pseudo-differential results below zero clamp to zero.
  always_comb begin
    w_hold_val = w_sdi_lvl ? ch1_data : ch0_data;
    w_diff     = w_sdi_lvl ? ({1'b0, ch1_data} - {1'b0, ch0_data})
                           : ({1'b0, ch0_data} - {1'b0, ch1_data});
    if (!r_sgl) begin
      w_hold_val = w_diff[DATA_W] ? '0 : w_diff[DATA_W-1:0];
    end
  end

  // Register all FSM state and outputs.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cfg_cnt     <= '0;
      r_sgl         <= 1'b0;
      r_odd         <= 1'b0;
      r_msbf_unused <= 1'b0;
      r_hold        <= '0;
      r_bit_idx     <= '0;
      r_sdo         <= 1'b0;
      r_sdo_oe      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_abort       <= 1'b0;
      r_last_sample <= '0;
      r_last_chan   <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_cfg_cnt     <= w_nxt_cfg_cnt;
      r_sgl         <= w_nxt_sgl;
      r_odd         <= w_nxt_odd;
      r_msbf_unused <= w_nxt_msbf;
      r_hold        <= w_nxt_hold;
      r_bit_idx     <= w_nxt_bit_idx;
      r_sdo         <= w_nxt_sdo;
      r_sdo_oe      <= w_nxt_sdo_oe;
      r_frame_done  <= w_nxt_frame_done;
      r_abort       <= w_nxt_abort;
      r_last_sample <= w_nxt_last_sample;
      r_last_chan   <= w_nxt_last_chan;
    end
  end

  // Next-state logic: cs events take priority over any coincident SCK edge.
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_cfg_cnt     = r_cfg_cnt;
    w_nxt_sgl         = r_sgl;
    w_nxt_odd         = r_odd;
    w_nxt_msbf        = r_msbf_unused;
    w_nxt_hold        = r_hold;
    w_nxt_bit_idx     = r_bit_idx;
    w_nxt_sdo         = r_sdo;
    w_nxt_sdo_oe      = r_sdo_oe;
    w_nxt_frame_done  = 1'b0;
    w_nxt_abort       = 1'b0;
    w_nxt_last_sample = r_last_sample;
    w_nxt_last_chan   = r_last_chan;

    if (w_cs_rise) begin
      w_nxt_state  = ST_IDLE;
      w_nxt_sdo    = 1'b0;
      w_nxt_sdo_oe = 1'b0;
      w_nxt_abort  = (r_state == ST_CONFIG) || (r_state == ST_DATA);
    end else if (w_cs_fall) begin
      w_nxt_state   = ST_WAIT_START;
      w_nxt_sdo     = 1'b0;
      w_nxt_sdo_oe  = 1'b0;
      w_nxt_cfg_cnt = '0;
    end else if (!w_cs_lvl) begin
      unique case (r_state)
        ST_IDLE: begin
        end
        ST_WAIT_START: begin
          if (w_sck_rise && w_sdi_lvl) begin
            w_nxt_state   = ST_CONFIG;
            w_nxt_cfg_cnt = '0;
          end
        end
        ST_CONFIG: begin
          if (w_sck_rise && (r_cfg_cnt != CNT_DONE)) begin
            if (r_cfg_cnt == CNT_SGL) begin
              w_nxt_sgl = w_sdi_lvl;
            end else if (r_cfg_cnt == CNT_ODD) begin
              w_nxt_odd  = w_sdi_lvl;
              w_nxt_hold = w_hold_val;
            end else begin
              w_nxt_msbf = w_sdi_lvl;
            end
            w_nxt_cfg_cnt = r_cfg_cnt + 1'b1;
          end else if (w_sck_fall && (r_cfg_cnt == CNT_DONE)) begin
            w_nxt_sdo_oe  = 1'b1;
            w_nxt_sdo     = 1'b0;
            w_nxt_bit_idx = IDX_MSB;
            w_nxt_state   = ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_sck_fall) begin
            w_nxt_sdo = r_hold[r_bit_idx];
            if (r_bit_idx == '0) begin
              w_nxt_frame_done  = 1'b1;
              w_nxt_last_sample = r_hold;
              w_nxt_last_chan   = r_odd;
              w_nxt_state       = ST_TRAIL;
            end else begin
              w_nxt_bit_idx = r_bit_idx - 1'b1;
            end
          end
        end
        ST_TRAIL: begin
          if (w_sck_fall) begin
            w_nxt_sdo = 1'b0;
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
        end
      endcase
    end
  end

  assign sdata_from_adc = r_sdo;
  assign sdo_oe         = r_sdo_oe;
  assign frame_done     = r_frame_done;
  assign abort_err      = r_abort;
  assign last_sample    = r_last_sample;
  assign last_chan      = r_last_chan;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed testbench for spi_adc_responder.
module tb_spi_adc_responder;

  localparam int HALF = 8;  // SCK half period in sysclk cycles

  logic       sysclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       adc_cs = 1'b1;
  logic       adc_sck = 1'b0;
  logic       sdata_to_adc = 1'b0;
  logic       sdata_from_adc;
  logic       sdo_oe;
  logic [9:0] ch0_data = '0;
  logic [9:0] ch1_data = '0;
  logic       frame_done;
  logic [9:0] last_sample;
  logic       last_chan;
  logic       abort_err;

  int checks = 0;
  int failures = 0;
  int n_done = 0;
  int n_abort = 0;

  spi_adc_responder #(.SYNC_STAGES(2), .DATA_W(10)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .adc_cs(adc_cs), .adc_sck(adc_sck),
    .sdata_to_adc(sdata_to_adc), .sdata_from_adc(sdata_from_adc), .sdo_oe(sdo_oe),
    .ch0_data(ch0_data), .ch1_data(ch1_data), .frame_done(frame_done),
    .last_sample(last_sample), .last_chan(last_chan), .abort_err(abort_err)
  );

  always #10 sysclk = ~sysclk;

  // Pulse counters for frame_done / abort_err.
  always @(posedge sysclk) begin
    if (frame_done) n_done <= n_done + 1;
    if (abort_err)  n_abort <= n_abort + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitclk(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // Clock nb bits of mosi MSB-first; capture miso/oe just before each rising SCK.
  task automatic xfer(input int nb, input logic [31:0] mosi, input int chg_at,
                      input logic [9:0] chg_val, output logic [31:0] miso,
                      output logic [31:0] oe);
    miso = '0;
    oe = '0;
    for (int i = 0; i < nb; i++) begin
      sdata_to_adc = mosi[nb-1-i];
      waitclk(HALF);
      miso = {miso[30:0], sdata_from_adc};
      oe   = {oe[30:0], sdo_oe};
      adc_sck = 1'b1;
      waitclk(HALF);
      if (i == chg_at) ch0_data = chg_val;
      adc_sck = 1'b0;
    end
    sdata_to_adc = 1'b0;
  endtask

  // Full frame: lead zeros, 4-bit command, 12 more clocks (null, 10 data, 1 trailer).
  task automatic frame(input string tag, input int lead, input logic [3:0] cmd,
                       input logic [9:0] exp_data, input logic exp_chan,
                       input int chg_at, input logic [9:0] chg_val);
    logic [31:0] miso, oe, mosi;
    int d0, a0;
    d0 = n_done;
    a0 = n_abort;
    mosi = {28'b0, cmd} << 12;
    adc_cs = 1'b0;
    waitclk(HALF);
    xfer(lead + 16, mosi, chg_at, chg_val, miso, oe);
    waitclk(HALF);
    adc_cs = 1'b1;
    waitclk(HALF);
    chk({tag, "_miso"}, miso, {21'b0, exp_data, 1'b0});
    chk({tag, "_oe"}, oe, 32'h0000_0FFF);
    chk({tag, "_done_cnt"}, n_done - d0, 1);
    chk({tag, "_abort_cnt"}, n_abort - a0, 0);
    chk({tag, "_last_sample"}, {22'b0, last_sample}, {22'b0, exp_data});
    chk({tag, "_last_chan"}, {31'b0, last_chan}, {31'b0, exp_chan});
    chk({tag, "_oe_idle"}, {31'b0, sdo_oe}, 0);
  endtask

  initial begin
    logic [31:0] miso, oe;
    int d0, a0;

    // Reset
    waitclk(4);
    chk("reset_outputs",
        {18'b0, sdata_from_adc, sdo_oe, frame_done, abort_err, last_chan, last_sample}, 0);
    rst_n = 1'b1;
    waitclk(HALF);

    // Single-ended CH1
    ch1_data = 10'h2A5;
    frame("se_ch1", 0, 4'b1111, 10'h2A5, 1'b1, -1, 10'h0);

    // Leading zeros, single-ended CH0
    ch0_data = 10'h3FF;
    frame("lead0", 3, 4'b1101, 10'h3FF, 1'b0, -1, 10'h0);

    // Pseudo-differential
    ch0_data = 10'd100;
    ch1_data = 10'd300;
    frame("diff_odd1", 0, 4'b1011, 10'd200, 1'b1, -1, 10'h0);
    frame("diff_odd0", 0, 4'b1001, 10'd0, 1'b0, -1, 10'h0);

    // Hold point: ch0 changes during the odd-bit clock high phase
    ch0_data = 10'h155;
    frame("hold_a", 0, 4'b1101, 10'h155, 1'b0, 2, 10'h0AA);
    frame("hold_b", 0, 4'b1101, 10'h0AA, 1'b0, -1, 10'h0);

    // Abort after D5 driven
    ch1_data = 10'h2B4;
    d0 = n_done;
    a0 = n_abort;
    adc_cs = 1'b0;
    waitclk(HALF);
    xfer(10, {28'b0, 4'b1111} << 6, -1, 10'h0, miso, oe);
    waitclk(2);
    adc_cs = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    chk("abort_oe_off", {31'b0, sdo_oe}, 0);
    chk("abort_sdo_low", {31'b0, sdata_from_adc}, 0);
    waitclk(HALF);
    chk("abort_miso", miso, 32'h15);
    chk("abort_oe", oe, 32'h3F);
    chk("abort_cnt", n_abort - a0, 1);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_last_sample", {22'b0, last_sample}, 32'h0AA);
    chk("abort_last_chan", {31'b0, last_chan}, 0);

    // Reset in the middle of DATA
    ch1_data = 10'h1C7;
    a0 = n_abort;
    adc_cs = 1'b0;
    waitclk(HALF);
    xfer(10, {28'b0, 4'b1111} << 6, -1, 10'h0, miso, oe);
    chk("pre_rst_oe", {31'b0, sdo_oe}, 1);
    rst_n = 1'b0;
    @(posedge sysclk);
    #1;
    chk("midrst_outputs",
        {18'b0, sdata_from_adc, sdo_oe, frame_done, abort_err, last_chan, last_sample}, 0);
    @(negedge sysclk);
    rst_n = 1'b1;
    waitclk(HALF);
    adc_cs = 1'b1;
    waitclk(HALF);
    chk("midrst_no_abort", n_abort - a0, 0);
    frame("post_rst", 0, 4'b1111, 10'h1C7, 1'b1, -1, 10'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
